// File: rtl/max_pooling_controller.sv
`default_nettype none
// ============================================================================
// Module   : max_pooling_controller
// Brief    : Walks a stored feature map window by window in raster order,
//            gathers each POOL_SIZE x POOL_SIZE window from the input RAM,
//            hands it to the max_pooling unit and writes the pooled value
//            to the output RAM.
// Revision : 1.0 - initial release
// ============================================================================
module max_pooling_controller #(
    parameter int DATA_SIZE  = 8,
    parameter int POOL_SIZE  = 2,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int IN_ADDR_W  = 6,
    parameter int OUT_ADDR_W = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_en,
    output logic [IN_ADDR_W-1:0]              rd_addr,
    input  logic [DATA_SIZE-1:0]              rd_data,
    output logic                              pool_enable,
    output logic [DATA_SIZE*POOL_SIZE**2-1:0] pool_data,
    input  logic [DATA_SIZE-1:0]              pool_result,
    output logic                              wr_en,
    output logic [OUT_ADDR_W-1:0]             wr_addr,
    output logic [DATA_SIZE-1:0]              wr_data
);

    localparam int OUT_W = IMG_W / POOL_SIZE;
    localparam int OUT_H = IMG_H / POOL_SIZE;
    localparam int K_N   = POOL_SIZE * POOL_SIZE;
    localparam int K_W   = (K_N   > 1) ? $clog2(K_N)   : 1;
    localparam int C_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int R_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_POOL    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Reject geometries that cannot tile evenly or do not fit the address ports.
    if ((IMG_W % POOL_SIZE) != 0 || (IMG_H % POOL_SIZE) != 0) begin : g_bad_tiling
        $error("IMG_W and IMG_H must be multiples of POOL_SIZE");
    end
    if ((1 << IN_ADDR_W) < IMG_W * IMG_H) begin : g_bad_in_addr
        $error("IN_ADDR_W too small for IMG_W*IMG_H");
    end
    if ((1 << OUT_ADDR_W) < OUT_W * OUT_H) begin : g_bad_out_addr
        $error("OUT_ADDR_W too small for the pooled map");
    end

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [K_W-1:0]       r_k;
    logic [C_W-1:0]       r_ocol;
    logic [R_W-1:0]       r_orow;
    logic [DATA_SIZE-1:0] r_win [K_N];
    logic                 w_last_k;
    logic                 w_last_col;
    logic                 w_last_row;
    logic [IN_ADDR_W-1:0] w_rd_addr;
    logic [OUT_ADDR_W-1:0] w_wr_addr;

    assign w_last_k   = (r_k    == K_W'(K_N - 1));
    assign w_last_col = (r_ocol == C_W'(OUT_W - 1));
    assign w_last_row = (r_orow == R_W'(OUT_H - 1));

    // Slot k sits at row k/P, column k%P inside the current window.
    assign w_rd_addr = IN_ADDR_W'((int'(r_orow) * POOL_SIZE + int'(r_k) / POOL_SIZE) * IMG_W
                                  + int'(r_ocol) * POOL_SIZE + int'(r_k) % POOL_SIZE);
    assign w_wr_addr = OUT_ADDR_W'(int'(r_orow) * OUT_W + int'(r_ocol));

    // Window register flattened onto the datapath bus, slot k in the k-th lane.
    for (genvar i = 0; i < K_N; i++) begin : g_pack
        assign pool_data[i*DATA_SIZE +: DATA_SIZE] = r_win[i];
    end

    // State register; asynchronous reset returns to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing through read, capture, pool and write phases.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_READ;
            S_READ:    if (w_last_k) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_POOL;
            S_POOL:    w_state_nxt = S_WRITE;
            S_WRITE:   w_state_nxt = (w_last_col && w_last_row) ? S_DONE : S_READ;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode; everything outside its owning state is held at zero.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        pool_enable = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        case (r_state)
            S_READ: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = w_rd_addr;
            end
            S_CAPTURE: busy = 1'b1;
            S_POOL: begin
                busy        = 1'b1;
                pool_enable = 1'b1;
            end
            S_WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = w_wr_addr;
                wr_data = pool_result;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Counters and window capture; RAM data lags the strobe by one cycle,
    // so each READ cycle stores the previous slot and CAPTURE stores the last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_ocol <= '0;
            r_orow <= '0;
            for (int i = 0; i < K_N; i++) r_win[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k    <= '0;
                    r_ocol <= '0;
                    r_orow <= '0;
                    for (int i = 0; i < K_N; i++) r_win[i] <= '0;
                end
                S_READ: begin
                    if (r_k != '0) r_win[r_k - K_W'(1)] <= rd_data;
                    r_k <= w_last_k ? '0 : r_k + K_W'(1);
                end
                S_CAPTURE: r_win[K_W'(K_N - 1)] <= rd_data;
                S_WRITE: begin
                    if (w_last_col) begin
                        r_ocol <= '0;
                        r_orow <= w_last_row ? '0 : r_orow + R_W'(1);
                    end else begin
                        r_ocol <= r_ocol + C_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_max_pooling_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pooling_controller
// Brief    : Directed bench for max_pooling_controller with an input RAM,
//            a registered max-of-window unit and write/read/pool logs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pooling_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy, done, rd_en, pool_enable, wr_en;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [31:0] pool_data;
    logic [7:0]  pool_result;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;

    logic [7:0]  mem [64];

    int cyc = 0;
    int t0 = 0;
    int total = 0;
    int bad = 0;

    int wr_total = 0;
    int rd_total = 0;
    int pool_total = 0;
    int done_total = 0;
    int done_cyc = 0;
    logic [3:0]  wlog_addr [256];
    logic [7:0]  wlog_data [256];
    int          wlog_cyc  [256];
    logic [5:0]  rlog      [1024];
    logic [31:0] plog      [256];

    max_pooling_controller #(
        .DATA_SIZE(8), .POOL_SIZE(2), .IMG_W(8), .IMG_H(8),
        .IN_ADDR_W(6), .OUT_ADDR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pool_enable(pool_enable), .pool_data(pool_data), .pool_result(pool_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input RAM: one-cycle read latency.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    function automatic logic [7:0] max4(input logic [31:0] v);
        logic [7:0] m;
        m = v[7:0];
        for (int i = 1; i < 4; i++) if (v[i*8 +: 8] > m) m = v[i*8 +: 8];
        return m;
    endfunction

    // Registered max_pooling datapath stand-in.
    always @(posedge clk) if (pool_enable) pool_result <= max4(pool_data);

    // Activity logs sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en && wr_total < 256) begin
            wlog_addr[wr_total] <= wr_addr;
            wlog_data[wr_total] <= wr_data;
            wlog_cyc[wr_total]  <= cyc;
        end
        if (wr_en) wr_total <= wr_total + 1;
        if (rd_en && rd_total < 1024) rlog[rd_total] <= rd_addr;
        if (rd_en) rd_total <= rd_total + 1;
        if (pool_enable && pool_total < 256) plog[pool_total] <= pool_data;
        if (pool_enable) pool_total <= pool_total + 1;
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc - t0 < n) step();
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_total < target && n < 400) begin
            step();
            n++;
        end
        chk("done_seen", 32'(done_total >= target), 32'd1);
    endtask

    int w0, w1, d0, r0, p0, wrst;
    int exp_rd [8] = '{0, 1, 8, 9, 2, 3, 10, 11};
    logic [31:0] exp_pool [4] = '{32'h01010180, 32'h01018001, 32'h01800101, 32'h80010101};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        repeat (3) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", {27'd0, done, rd_en, pool_enable, wr_en, 1'b0}, 0);
        chk("rst_pool_data", pool_data, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Test 1: ramp image
        w0 = wr_total; d0 = done_total;
        pulse_start();
        wait_done(d0 + 1);
        chk("t1_nwr", 32'(wr_total - w0), 16);
        chk("t1_out0", wlog_data[w0], 9);
        chk("t1_out1", wlog_data[w0 + 1], 11);
        chk("t1_out4", wlog_data[w0 + 4], 25);
        chk("t1_out15", wlog_data[w0 + 15], 63);
        chk("t1_addr15", 32'(wlog_addr[w0 + 15]), 15);
        chk("t1_lastwr_cyc", 32'(wlog_cyc[w0 + 15] - t0), 112);
        chk("t1_done_cyc", 32'(done_cyc - t0), 113);
        step();
        chk("t1_idle_busy", 32'(busy), 0);

        // Test 2: max position sweep
        for (int a = 0; a < 64; a++) mem[a] = 8'h01;
        mem[0] = 8'h80; mem[3] = 8'h80; mem[12] = 8'h80; mem[15] = 8'h80;
        w0 = wr_total; d0 = done_total; p0 = pool_total;
        pulse_start();
        wait_done(d0 + 1);
        for (int j = 0; j < 4; j++) begin
            chk("t2_out", wlog_data[w0 + j], 8'h80);
            chk("t2_pool", plog[p0 + j], exp_pool[j]);
        end
        chk("t2_out4", wlog_data[w0 + 4], 8'h01);
        step();

        // Test 3: saturation and read-address order
        for (int a = 0; a < 64; a++) mem[a] = 8'hFF;
        w0 = wr_total; d0 = done_total; r0 = rd_total;
        pulse_start();
        wait_done(d0 + 1);
        for (int i = 0; i < 16; i++) chk("t3_out", wlog_data[w0 + i], 8'hFF);
        for (int i = 0; i < 8; i++) chk("t3_rd", 32'(rlog[r0 + i]), exp_rd[i]);
        step();

        // Test 4: start while busy and in DONE is ignored (reversed ramp)
        for (int a = 0; a < 64; a++) mem[a] = 8'(63 - a);
        w0 = wr_total; d0 = done_total;
        pulse_start();
        goto_cycle(20);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(d0 + 1);
        chk("t4_done_cyc", 32'(cyc - t0), 113);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        chk("t4_ndone", 32'(done_total - d0), 1);
        chk("t4_nwr", 32'(wr_total - w0), 16);
        chk("t4_out0", wlog_data[w0], 63);
        chk("t4_out15", wlog_data[w0 + 15], 9);
        chk("t4_busy", 32'(busy), 0);

        // Test 5: reset mid-pass, then restart
        for (int a = 0; a < 64; a++) mem[a] = 8'(a);
        pulse_start();
        goto_cycle(40);
        rst_n = 1'b0;
        #1;
        wrst = wr_total;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_strobes", {27'd0, done, rd_en, pool_enable, wr_en, 1'b0}, 0);
        chk("t5_addrs", {18'd0, rd_addr, wr_addr, wr_data}, 0);
        chk("t5_pool_data", pool_data, 0);
        goto_cycle(45);
        rst_n = 1'b1;
        repeat (10) step();
        chk("t5_nwr_after_rst", 32'(wr_total - wrst), 0);
        chk("t5_busy_idle", 32'(busy), 0);
        w1 = wr_total; d0 = done_total;
        pulse_start();
        wait_done(d0 + 1);
        chk("t5_nwr", 32'(wr_total - w1), 16);
        chk("t5_addr0", 32'(wlog_addr[w1]), 0);
        chk("t5_out0", wlog_data[w1], 9);
        chk("t5_out4", wlog_data[w1 + 4], 25);
        chk("t5_out15", wlog_data[w1 + 15], 63);
        step();

        // Test 6: start held high, two back-to-back passes
        w0 = wr_total; d0 = done_total;
        start = 1'b1;
        t0 = cyc;
        wait_done(d0 + 1);
        wait_done(d0 + 2);
        start = 1'b0;
        chk("t6_done2_cyc", 32'(done_cyc - t0), 227);
        chk("t6_p2_first_cyc", 32'(wlog_cyc[w0 + 16] - t0), 121);
        chk("t6_p2_addr0", 32'(wlog_addr[w0 + 16]), 0);
        chk("t6_p2_out0", wlog_data[w0 + 16], 9);
        chk("t6_p2_out15", wlog_data[w0 + 31], 63);
        repeat (20) step();
        chk("t6_ndone", 32'(done_total - d0), 2);
        chk("t6_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
